// File: rtl/rl_line_scheduler_pkg.sv
// Shared constants, state encoding and small helpers for the run-length line-bank scheduler.
package rl_line_scheduler_pkg;

    localparam int AW           = 11;
    localparam int DEPTH        = 1040;
    localparam int ROWS         = 768;
    localparam int ACTIVE_WIDTH = 1024;

    localparam logic [AW-1:0] SENTINEL  = 11'd2047;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
    localparam logic [AW-1:0] FIRST_ROW = 11'd0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_WAIT_ROW = 3'd2,
        ST_ROW      = 3'd3,
        ST_ANALYZE  = 3'd4
    } state_e;

    // Even rows live in bank 0, odd rows in bank 1.
    function automatic logic bank_of(input logic [AW-1:0] idx);
        return idx[0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rl_line_scheduler_if.sv
// Handshake bundle between VGA indexing / encoder / analyzer (master side) and the line scheduler (slave side).
interface rl_line_scheduler_if;
    import rl_line_scheduler_pkg::*;

    logic          frame_start;
    logic          row_start;
    logic [AW-1:0] row_idx;
    logic          enc_done;
    logic          ana_done;
    logic          enc_go;
    logic          wr_bank;
    logic          ana_go;
    logic          ana_first_row;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] clr_data;
    logic          busy;
    logic          overrun;
    logic [7:0]    overrun_cnt;

    modport master (
        output frame_start, row_start, row_idx, enc_done, ana_done,
        input  enc_go, wr_bank, ana_go, ana_first_row, clr_we, clr_addr,
               clr_data, busy, overrun, overrun_cnt
    );

    modport slave (
        input  frame_start, row_start, row_idx, enc_done, ana_done,
        output enc_go, wr_bank, ana_go, ana_first_row, clr_we, clr_addr,
               clr_data, busy, overrun, overrun_cnt
    );

endinterface

// File: rtl/rl_clear_sequencer.sv
// Walks the bank address range once per start pulse; a start while active restarts at address 0.
module rl_clear_sequencer
    import rl_line_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic          done_o
);

    logic          active_q, active_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          at_last_s;

    assign at_last_s = (addr_q == LAST_ADDR);

    // Next address / active flag.
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        if (start_i) begin
            active_d = 1'b1;
            addr_d   = {AW{1'b0}};
        end else if (active_q && at_last_s) begin
            active_d = 1'b0;
            addr_d   = {AW{1'b0}};
        end else if (active_q) begin
            addr_d   = addr_q + 11'd1;
        end else begin
            addr_d   = addr_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            addr_q   <= {AW{1'b0}};
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
        end
    end

    assign we_o   = active_q;
    assign addr_o = addr_q;
    assign done_o = active_q && at_last_s;

endmodule

// File: rtl/rl_line_scheduler.sv
// Sequences the even/odd run-length line banks between the row encoder and the two-line blob analyzer.
module rl_line_scheduler
    import rl_line_scheduler_pkg::*;
(
    input  logic                VGA_IN_DATA_CLK,
    input  logic                rst_n,
    rl_line_scheduler_if.slave  bus
);

    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_idx_q, pend_idx_d;
    logic          bank_q, bank_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          enc_go_q, busy_q, ana_go_q;
    logic          ana_go_d;
    logic          take_s;
    logic [AW-1:0] take_idx_s;
    logic          clr_we_s, clr_done_s;
    logic [AW-1:0] clr_addr_s;

    rl_clear_sequencer u_clear (
        .clk     (VGA_IN_DATA_CLK),
        .rst_n   (rst_n),
        .start_i (bus.frame_start),
        .we_o    (clr_we_s),
        .addr_o  (clr_addr_s),
        .done_o  (clr_done_s)
    );

    // Next-state logic; take_s marks "start a new row from take_idx_s".
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        bank_d     = bank_q;
        first_d    = first_q;
        last_d     = last_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        ana_go_d   = 1'b0;
        take_s     = 1'b0;
        take_idx_s = bus.row_idx;

        if (bus.frame_start) begin
            state_d    = ST_CLEAR;
            cnt_d      = 8'd0;
            pend_d     = bus.row_start;
            pend_idx_d = bus.row_idx;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_CLEAR: begin
                    if (clr_done_s && bus.row_start) begin
                        take_s = 1'b1;
                        pend_d = 1'b0;
                    end else if (clr_done_s && pend_q) begin
                        take_s     = 1'b1;
                        take_idx_s = pend_idx_q;
                        pend_d     = 1'b0;
                    end else if (clr_done_s) begin
                        state_d = ST_WAIT_ROW;
                    end else if (bus.row_start) begin
                        pend_d     = 1'b1;
                        pend_idx_d = bus.row_idx;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_WAIT_ROW: begin
                    if (bus.row_start) begin
                        take_s = 1'b1;
                    end else if (pend_q) begin
                        take_s     = 1'b1;
                        take_idx_s = pend_idx_q;
                        pend_d     = 1'b0;
                    end else begin
                        state_d = ST_WAIT_ROW;
                    end
                end
                ST_ROW: begin
                    // A new row_start wins over enc_done: the current row is abandoned.
                    if (bus.row_start) begin
                        take_s    = 1'b1;
                        overrun_d = 1'b1;
                        cnt_d     = sat_inc8(cnt_q);
                    end else if (bus.enc_done && first_q) begin
                        state_d = ST_WAIT_ROW;
                    end else if (bus.enc_done) begin
                        state_d  = ST_ANALYZE;
                        ana_go_d = 1'b1;
                    end else begin
                        state_d = ST_ROW;
                    end
                end
                ST_ANALYZE: begin
                    if (bus.row_start) begin
                        take_s    = 1'b1;
                        overrun_d = 1'b1;
                        cnt_d     = sat_inc8(cnt_q);
                    end else if (bus.ana_done) begin
                        state_d = last_q ? ST_IDLE : ST_WAIT_ROW;
                    end else begin
                        state_d = ST_ANALYZE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (take_s) begin
            state_d = ST_ROW;
            bank_d  = bank_of(take_idx_s);
            first_d = (take_idx_s == FIRST_ROW);
            last_d  = (take_idx_s == LAST_ROW);
        end else begin
            bank_d  = bank_q;
            first_d = first_q;
            last_d  = last_q;
        end
    end

    // State, row context and registered outputs.
    always_ff @(posedge VGA_IN_DATA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            pend_idx_q <= {AW{1'b0}};
            bank_q     <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= 8'd0;
            enc_go_q   <= 1'b0;
            busy_q     <= 1'b0;
            ana_go_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            bank_q     <= bank_d;
            first_q    <= first_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            enc_go_q   <= (state_d == ST_ROW);
            busy_q     <= (state_d != ST_IDLE);
            ana_go_q   <= ana_go_d;
        end
    end

    assign bus.enc_go        = enc_go_q;
    assign bus.wr_bank       = bank_q;
    assign bus.ana_go        = ana_go_q;
    assign bus.ana_first_row = first_q;
    assign bus.clr_we        = clr_we_s;
    assign bus.clr_addr      = clr_addr_s;
    assign bus.clr_data      = SENTINEL;
    assign bus.busy          = busy_q;
    assign bus.overrun       = overrun_q;
    assign bus.overrun_cnt   = cnt_q;

endmodule

// File: tb/tb_rl_line_scheduler.sv
// Directed, table-driven bench for rl_line_scheduler with hand-written clear/overrun sequences.
module tb_rl_line_scheduler;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    rl_line_scheduler_if bus ();

    rl_line_scheduler dut (
        .VGA_IN_DATA_CLK (clk),
        .rst_n           (rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fs;
        logic        rs;
        logic [10:0] idx;
        logic        ed;
        logic        ad;
        logic        e_enc;
        logic        e_bank;
        logic        e_ana;
        logic        e_first;
        logic        e_busy;
        logic        e_clr;
        logic        e_ovr;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(input logic fs, input logic rs, input int idx,
                                input logic ed, input logic ad,
                                input logic enc, input logic bank, input logic ana,
                                input logic first, input logic busy, input logic clr,
                                input logic ovr, input int cnt);
        vec_t v;
        v.fs = fs; v.rs = rs; v.idx = 11'(idx); v.ed = ed; v.ad = ad;
        v.e_enc = enc; v.e_bank = bank; v.e_ana = ana; v.e_first = first;
        v.e_busy = busy; v.e_clr = clr; v.e_ovr = ovr; v.e_cnt = 8'(cnt);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        bus.row_start   = 1'b0;
        bus.enc_done    = 1'b0;
        bus.ana_done    = 1'b0;
    endtask

    task automatic apply(input int i);
        vec_t v;
        v = vecs[i];
        bus.frame_start = v.fs;
        bus.row_start   = v.rs;
        bus.row_idx     = v.idx;
        bus.enc_done    = v.ed;
        bus.ana_done    = v.ad;
        step();
        chk("enc_go",      i, bus.enc_go,        v.e_enc);
        chk("wr_bank",     i, bus.wr_bank,       v.e_bank);
        chk("ana_go",      i, bus.ana_go,        v.e_ana);
        chk("first_row",   i, bus.ana_first_row, v.e_first);
        chk("busy",        i, bus.busy,          v.e_busy);
        chk("clr_we",      i, bus.clr_we,        v.e_clr);
        chk("overrun",     i, bus.overrun,       v.e_ovr);
        chk("overrun_cnt", i, bus.overrun_cnt,   v.e_cnt);
    endtask

    // Follows an active clear to its end, optionally injecting a row_start at a given address.
    task automatic run_clear(input int inj_at, input int inj_idx, input int tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (bus.clr_we === 1'b1 && n < 2000) begin
            if (bus.clr_addr !== n[10:0] || bus.clr_data !== 11'd2047) bad++;
            if (n == inj_at) begin
                bus.row_start = 1'b1;
                bus.row_idx   = 11'(inj_idx);
            end
            n++;
            step();
        end
        chk("clear_len",  tag, n,   1040);
        chk("clear_addr", tag, bad, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_checks = 0;
        n_err    = 0;
        rst_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.row_start   = 1'b0;
        bus.row_idx     = 11'd0;
        bus.enc_done    = 1'b0;
        bus.ana_done    = 1'b0;

        //               fs rs idx ed ad  enc bnk ana fst bsy clr ovr cnt
        vecs[0]  = mk(0, 1, 0,   0, 0,  1, 0, 0, 1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,   0, 0,  1, 0, 0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,   1, 0,  0, 0, 0, 1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1,   0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0,   1, 0,  0, 1, 1, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0,   0, 0,  0, 1, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0,   0, 1,  0, 1, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 5,   0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0,   1, 0,  0, 1, 1, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 6,   0, 0,  1, 0, 0, 0, 1, 0, 1, 1);
        vecs[10] = mk(0, 0, 0,   1, 0,  0, 0, 1, 0, 1, 0, 1, 1);
        vecs[11] = mk(0, 0, 0,   0, 1,  0, 0, 0, 0, 1, 0, 1, 1);
        vecs[12] = mk(0, 1, 8,   0, 0,  1, 0, 0, 0, 1, 0, 1, 1);
        vecs[13] = mk(0, 1, 9,   1, 0,  1, 1, 0, 0, 1, 0, 1, 2);
        vecs[14] = mk(0, 0, 0,   0, 0,  1, 1, 0, 0, 1, 0, 1, 2);
        vecs[15] = mk(1, 1, 10,  0, 0,  0, 1, 0, 0, 1, 1, 1, 0);
        vecs[16] = mk(0, 0, 0,   1, 0,  0, 0, 1, 0, 1, 0, 1, 0);
        vecs[17] = mk(0, 0, 0,   0, 1,  0, 0, 0, 0, 1, 0, 1, 0);
        vecs[18] = mk(0, 1, 767, 0, 0,  1, 1, 0, 0, 1, 0, 1, 0);
        vecs[19] = mk(0, 0, 0,   1, 0,  0, 1, 1, 0, 1, 0, 1, 0);
        vecs[20] = mk(0, 0, 0,   0, 1,  0, 1, 0, 0, 0, 0, 1, 0);
        vecs[21] = mk(0, 1, 0,   0, 0,  0, 1, 0, 0, 0, 0, 1, 0);
        vecs[22] = mk(0, 0, 0,   0, 0,  0, 1, 0, 0, 0, 0, 1, 0);

        step();
        step();
        chk("rst_enc_go",   0, bus.enc_go,      0);
        chk("rst_busy",     0, bus.busy,        0);
        chk("rst_clr_we",   0, bus.clr_we,      0);
        chk("rst_clr_addr", 0, bus.clr_addr,    0);
        chk("rst_clr_data", 0, bus.clr_data,    2047);
        chk("rst_ovr_cnt",  0, bus.overrun_cnt, 0);

        // Reset asserted in the middle of a clear.
        rst_n = 1'b1;
        step();
        bus.frame_start = 1'b1;
        step();
        k = 0;
        while (bus.clr_addr !== 11'd500 && k < 2000) begin
            step();
            k++;
        end
        chk("reach_addr500", 0, bus.clr_addr, 500);
        rst_n = 1'b0;
        #1;
        chk("midrst_clr_we",   1, bus.clr_we,        0);
        chk("midrst_clr_addr", 1, bus.clr_addr,      0);
        chk("midrst_busy",     1, bus.busy,          0);
        chk("midrst_enc_go",   1, bus.enc_go,        0);
        chk("midrst_ana_go",   1, bus.ana_go,        0);
        chk("midrst_wr_bank",  1, bus.wr_bank,       0);
        chk("midrst_first",    1, bus.ana_first_row, 0);
        chk("midrst_clr_data", 1, bus.clr_data,      2047);
        step();
        rst_n = 1'b1;
        step();

        // Full clear, then normal rows, overruns and a frame_start/row_start collision.
        bus.frame_start = 1'b1;
        step();
        run_clear(-1, 0, 0);
        chk("wait_busy",   0, bus.busy,   1);
        chk("wait_enc_go", 0, bus.enc_go, 0);
        for (int i = 0; i <= 15; i++) apply(i);

        run_clear(-1, 0, 1);
        chk("pend_enc_go",  1, bus.enc_go,        1);
        chk("pend_wr_bank", 1, bus.wr_bank,       0);
        chk("pend_first",   1, bus.ana_first_row, 0);
        chk("pend_cnt",     1, bus.overrun_cnt,   0);

        // Last row of the frame returns to IDLE; later row_starts are ignored.
        for (int i = 16; i <= 22; i++) apply(i);

        // Early row_start at clear address 100.
        bus.frame_start = 1'b1;
        step();
        run_clear(100, 3, 2);
        chk("early_enc_go",  2, bus.enc_go,        1);
        chk("early_wr_bank", 2, bus.wr_bank,       1);
        chk("early_first",   2, bus.ana_first_row, 0);
        chk("early_ana_go",  2, bus.ana_go,        0);
        chk("early_cnt",     2, bus.overrun_cnt,   0);

        // 300 back-to-back overruns saturate the counter.
        for (int i = 0; i < 300; i++) begin
            bus.row_start = 1'b1;
            bus.row_idx   = 11'(i);
            step();
        end
        chk("sat_cnt",     3, bus.overrun_cnt, 255);
        chk("sat_overrun", 3, bus.overrun,     1);
        chk("sat_enc_go",  3, bus.enc_go,      1);
        chk("sat_wr_bank", 3, bus.wr_bank,     1);

        bus.frame_start = 1'b1;
        step();
        chk("fs_cnt_clr",  4, bus.overrun_cnt, 0);
        chk("fs_ovr_keep", 4, bus.overrun,     1);
        chk("fs_enc_go",   4, bus.enc_go,      0);
        chk("fs_clr_we",   4, bus.clr_we,      1);
        chk("fs_clr_addr", 4, bus.clr_addr,    0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
